// File: rtl/fp_rnd_pipe.sv
// rtl/fp_rnd_pipe.sv - pipelined IEEE-754 round and pack stage
//
// Purpose: rounds an unrounded sign/exponent/significand with guard, round
// and sticky bits from an upstream arithmetic unit, resolves special cases
// and packs the result with exception flags. Two-stage valid/ready pipeline
// with backpressure, flush and an opaque pass-through tag.
//
// Parameters: EXP_W exponent field width, MAN_W stored fraction width,
//             TAG_W tag width.
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   flush                   drops every in-flight operation
//   in_valid / in_ready     input handshake
//   in_sig, in_expo, in_mant, in_grs, in_rm    operand and rounding mode
//   in_snan, in_qnan, in_dbz, in_infs, in_zero, in_diff   classification
//   in_tag                  returned unchanged with the result
//   out_valid / out_ready   output handshake
//   out_result, out_flags ({NV,DZ,OF,UF,NX}), out_tag
//
// Build option: FP_RND_SUBNORM_EN defined produces subnormal results;
// undefined flushes tiny non-zero results to a signed zero.

module fp_rnd_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sig,
   input  logic [EXP_W+1:0]         in_expo,
   input  logic [MAN_W+1:0]         in_mant,
   input  logic [2:0]               in_grs,
   input  logic [2:0]               in_rm,
   input  logic                     in_snan,
   input  logic                     in_qnan,
   input  logic                     in_dbz,
   input  logic                     in_infs,
   input  logic                     in_zero,
   input  logic                     in_diff,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_result,
   output logic [4:0]               out_flags,
   output logic [TAG_W-1:0]         out_tag
);

   localparam int RES_W = EXP_W + MAN_W + 1;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam logic [EXP_W-1:0] EXP_ONES  = '1;
   localparam logic [EXP_W-1:0] EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
   localparam logic [MAN_W-1:0] FRAC_ONES = '1;
   localparam logic [MAN_W-1:0] FRAC_ZERO = '0;
   localparam logic [MAN_W-1:0] FRAC_QNAN = {1'b1, {(MAN_W-1){1'b0}}};
   // 2^EXP_W - 1 in the widened two's complement exponent
   localparam logic [EXP_W+1:0] EXP_OVF   = {2'b00, EXP_ONES};
   localparam logic [EXP_W+1:0] EXP_ONE   = {{(EXP_W+1){1'b0}}, 1'b1};

   localparam logic [RES_W-1:0] CANON_NAN = {1'b0, EXP_ONES, FRAC_QNAN};

   // pipeline control
   logic s1_valid;
   logic s1_en;
   logic s2_en;

   assign s2_en    = ~out_valid | out_ready;
   assign s1_en    = ~s1_valid | s2_en;
   assign in_ready = s1_en;

   // ---------------------------------------------------------------
   // Stage 1: rounding increment and subnormal promotion
   // ---------------------------------------------------------------
   logic             inexact;
   logic             rndup;
   logic             s1n_sig;
   logic             s1n_badrm;
   logic [EXP_W+1:0] s1n_expo;
   logic [MAN_W+1:0] s1n_mant;

   always_comb begin
      inexact = |in_grs;
      case (in_rm)
         RM_RNE:  rndup = in_grs[2] & (in_mant[0] | in_grs[1] | in_grs[0]);
         RM_RTZ:  rndup = 1'b0;
         RM_RDN:  rndup = in_sig & inexact;
         RM_RUP:  rndup = ~in_sig & inexact;
         RM_RMM:  rndup = in_grs[2];
         default: rndup = 1'b0;
      endcase
      s1n_badrm = (in_rm > RM_RMM);
      s1n_mant  = in_mant + {{(MAN_W+1){1'b0}}, rndup};
      s1n_expo  = in_expo;
      // rounding a subnormal up into the hidden bit makes it the smallest normal
      if ((in_expo == '0) && s1n_mant[MAN_W]) begin
         s1n_expo = EXP_ONE;
      end
      // exact zero from opposite-signed addends: +0 except when rounding down
      s1n_sig = (in_zero & in_diff) ? (in_rm == RM_RDN) : in_sig;
   end

   logic             s1_sig;
   logic [EXP_W+1:0] s1_expo;
   logic [MAN_W+1:0] s1_mant;
   logic             s1_inexact;
   logic [2:0]       s1_rm;
   logic             s1_badrm;
   logic             s1_snan;
   logic             s1_qnan;
   logic             s1_dbz;
   logic             s1_infs;
   logic             s1_zero;
   logic [TAG_W-1:0] s1_tag;

   // stage 1 payload needs no reset; it is qualified by s1_valid
   always_ff @(posedge clock) begin
      if (s1_en && in_valid) begin
         s1_sig     <= s1n_sig;
         s1_expo    <= s1n_expo;
         s1_mant    <= s1n_mant;
         s1_inexact <= inexact;
         s1_rm      <= in_rm;
         s1_badrm   <= s1n_badrm;
         s1_snan    <= in_snan;
         s1_qnan    <= in_qnan;
         s1_dbz     <= in_dbz;
         s1_infs    <= in_infs;
         s1_zero    <= in_zero;
         s1_tag     <= in_tag;
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: normalise, overflow/underflow, specials, pack
   // ---------------------------------------------------------------
   logic [MAN_W+1:0] n_mant;
   logic [EXP_W+1:0] n_expo;
   logic             ovf;
   logic             tiny;
   logic             to_inf;
   logic [RES_W-1:0] n_result;
   logic [4:0]       n_flags;

   always_comb begin
      n_mant = s1_mant;
      n_expo = s1_expo;
      if (s1_mant[MAN_W+1]) begin
         n_mant = s1_mant >> 1;
         n_expo = s1_expo + EXP_ONE;
      end

      // exponent is two's complement: sign bit set means below the normal range
      ovf    = ~n_expo[EXP_W+1] & (n_expo >= EXP_OVF);
      tiny   = n_expo[EXP_W+1] | (n_expo == '0);
      to_inf = (s1_rm == RM_RNE) | (s1_rm == RM_RMM) |
               ((s1_rm == RM_RDN) & s1_sig) | ((s1_rm == RM_RUP) & ~s1_sig);

      n_result = {s1_sig, n_expo[EXP_W-1:0], n_mant[MAN_W-1:0]};
      n_flags  = {4'b0000, s1_inexact};

      if (s1_snan | s1_badrm) begin
         n_result = CANON_NAN;
         n_flags  = 5'b10000;
      end else if (s1_qnan) begin
         n_result = CANON_NAN;
         n_flags  = 5'b00000;
      end else if (s1_dbz) begin
         n_result = {s1_sig, EXP_ONES, FRAC_ZERO};
         n_flags  = 5'b01000;
      end else if (s1_infs) begin
         n_result = {s1_sig, EXP_ONES, FRAC_ZERO};
         n_flags  = 5'b00000;
      end else if (s1_zero) begin
         n_result = {s1_sig, {(RES_W-1){1'b0}}};
         n_flags  = 5'b00000;
      end else if (ovf) begin
         n_result = to_inf ? {s1_sig, EXP_ONES, FRAC_ZERO}
                           : {s1_sig, EXP_MAXF, FRAC_ONES};
         n_flags  = 5'b00101;
      end else if (tiny) begin
         if (|n_mant[MAN_W:0]) begin
`ifdef FP_RND_SUBNORM_EN
            n_result = {s1_sig, {EXP_W{1'b0}}, n_mant[MAN_W-1:0]};
            n_flags  = {3'b000, s1_inexact, s1_inexact};
`else
            n_result = {s1_sig, {(RES_W-1){1'b0}}};
            n_flags  = 5'b00011;
`endif
         end else begin
            n_result = {s1_sig, {(RES_W-1){1'b0}}};
         end
      end
   end

   // ---------------------------------------------------------------
   // Valid bits and output register
   // ---------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
         out_tag    <= '0;
      end else if (flush) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (s1_en) begin
            s1_valid <= in_valid;
         end
         if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_result <= n_result;
               out_flags  <= n_flags;
               out_tag    <= s1_tag;
            end
         end
      end
   end

endmodule
